lsu_controller: RTL and testbench

Multi-cycle load/store sequencer between the single-cycle core's execute stage and a data memory with variable latency. Accepts one load or store at a time, stalls the core while the access is in flight, and drives a word-aligned memory request/acknowledge handshake with byte strobes. Returns sign- or zero-extended load data aligned from the addressed byte lane, and reports misaligned, illegal-width and timeout errors.

---
 rtl/lsu_controller.sv | 174 +++++++++++++++++
 tb/tb_lsu_controller.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/lsu_controller.sv
// rtl/lsu_controller.sv - load/store sequencer between core execute stage and variable-latency data memory.
module lsu_controller #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ls_valid,
  input  logic [6:0]  opcode,
  input  logic [2:0]  fn3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic        done,
  output logic [31:0] rdata,
  output logic [1:0]  exc_code,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);
  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

  state_t      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]  fn3_q, fn3_d;
  logic [1:0]  off_q, off_d;
  logic        done_q, done_d;
  logic [31:0] rdata_q, rdata_d;
  logic [1:0]  exc_q, exc_d;
  logic        req_q, req_d;
  logic        we_q, we_d;
  logic [31:0] maddr_q, maddr_d;
  logic [31:0] mwdata_q, mwdata_d;
  logic [3:0]  wstrb_q, wstrb_d;

  logic        is_ld, is_st, accept, illegal, misal;
  logic [31:0] st_data, ld_fmt;
  logic [3:0]  st_strb;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    fn3_d    = fn3_q;
    off_d    = off_q;
    done_d   = 1'b0;
    rdata_d  = rdata_q;
    exc_d    = exc_q;
    req_d    = req_q;
    we_d     = we_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    wstrb_d  = wstrb_q;

    is_ld  = (opcode == 7'b0000011);
    is_st  = (opcode == 7'b0100011);
    accept = (state_q == S_IDLE) && ls_valid && (is_ld || is_st);

    // Stores allow only 000/001/010; loads additionally allow 100/101.
    illegal = is_st ? (fn3[2] || fn3 == 3'b011) : (fn3 == 3'b011 || fn3[2:1] == 2'b11);
    misal   = (fn3[1:0] == 2'b01 && addr[0]) || (fn3[1:0] == 2'b10 && addr[1:0] != 2'b00);

    case (fn3[1:0])
      2'b00: begin
        st_data = {4{wdata[7:0]}};
        st_strb = 4'b0001 << addr[1:0];
      end
      2'b01: begin
        st_data = {2{wdata[15:0]}};
        st_strb = addr[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_data = wdata;
        st_strb = 4'b1111;
      end
    endcase

    ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (fn3_q)
      3'b000:  ld_fmt = {{24{ld_byte[7]}}, ld_byte};
      3'b100:  ld_fmt = {24'h0, ld_byte};
      3'b001:  ld_fmt = {{16{ld_half[15]}}, ld_half};
      3'b101:  ld_fmt = {16'h0, ld_half};
      default: ld_fmt = mem_rdata;
    endcase

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          fn3_d = fn3;
          off_d = addr[1:0];
          if (illegal || misal) begin
            state_d = S_DONE;
            done_d  = 1'b1;
            exc_d   = illegal ? 2'b11 : 2'b01;
          end else begin
            state_d  = S_REQ;
            cnt_d    = '0;
            req_d    = 1'b1;
            we_d     = is_st;
            maddr_d  = {addr[31:2], 2'b00};
            mwdata_d = is_st ? st_data : 32'h0;
            wstrb_d  = is_st ? st_strb : 4'b0000;
          end
        end
      end
      S_REQ: begin
        if (mem_ack) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          exc_d   = 2'b00;
          req_d   = 1'b0;
          if (!we_q) rdata_d = ld_fmt;
        end else if (cnt_q == CW'(TIMEOUT - 1)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          exc_d   = 2'b10;
          req_d   = 1'b0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      fn3_q    <= 3'b000;
      off_q    <= 2'b00;
      done_q   <= 1'b0;
      rdata_q  <= 32'h0;
      exc_q    <= 2'b00;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      maddr_q  <= 32'h0;
      mwdata_q <= 32'h0;
      wstrb_q  <= 4'b0000;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      fn3_q    <= fn3_d;
      off_q    <= off_d;
      done_q   <= done_d;
      rdata_q  <= rdata_d;
      exc_q    <= exc_d;
      req_q    <= req_d;
      we_q     <= we_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      wstrb_q  <= wstrb_d;
    end
  end

  assign stall     = accept || (state_q == S_REQ);
  assign done      = done_q;
  assign rdata     = rdata_q;
  assign exc_code  = exc_q;
  assign mem_req   = req_q;
  assign mem_we    = we_q;
  assign mem_addr  = maddr_q;
  assign mem_wdata = mwdata_q;
  assign mem_wstrb = wstrb_q;
endmodule

// File: tb/tb_lsu_controller.sv
// tb/tb_lsu_controller.sv - scoreboard bench for lsu_controller.
module tb_lsu_controller;
  localparam int TMO = 4;
  localparam logic [6:0] OP_LD = 7'b0000011;
  localparam logic [6:0] OP_ST = 7'b0100011;

  logic        clk = 1'b0;
  logic        rst, ls_valid, mem_ack;
  logic [6:0]  opcode;
  logic [2:0]  fn3;
  logic [31:0] addr, wdata, mem_rdata;
  logic        stall, done, mem_req, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic [1:0]  exc_code;
  logic [3:0]  mem_wstrb;

  typedef struct packed {
    logic [31:0] rdata;
    logic [1:0]  exc;
  } exp_t;
  exp_t sb_q[$];

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] model_rdata = 32'h0;

  always #5 clk = ~clk;

  lsu_controller #(.TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .ls_valid(ls_valid), .opcode(opcode), .fn3(fn3),
    .addr(addr), .wdata(wdata), .stall(stall), .done(done), .rdata(rdata),
    .exc_code(exc_code), .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ld_model(input logic [2:0] f, input logic [1:0] o, input logic [31:0] w);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[8*o +: 8];
    h = o[1] ? w[31:16] : w[15:0];
    case (f)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] strb_model(input logic [2:0] f, input logic [1:0] o);
    logic [3:0] s;
    for (int i = 0; i < 4; i++)
      s[i] = (f == 3'b000 && i == int'(o)) || (f == 3'b001 && (i / 2) == int'(o[1])) || (f == 3'b010);
    return s;
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] f, input logic [31:0] wd);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = (f == 3'b000) ? wd[7:0] : (f == 3'b001) ? wd[8*(i%2) +: 8] : wd[8*i +: 8];
    return r;
  endfunction

  function automatic logic [1:0] exc_model(input logic st, input logic [2:0] f, input logic [31:0] a);
    logic legal;
    legal = st ? (f <= 3'b010) : (f <= 3'b010 || f == 3'b100 || f == 3'b101);
    if (!legal) return 2'b11;
    if ((f[1:0] == 2'b01 && a[0]) || (f[1:0] == 2'b10 && a[1:0] != 2'b00)) return 2'b01;
    return 2'b00;
  endfunction

  // ack_on = REQ cycle index on which memory acknowledges; 0 = never.
  task automatic run_op(input string nm, input logic st, input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] wd, input logic [31:0] rword, input int ack_on);
    exp_t e;
    int   exp_reqs, exp_lat, cyc, req_cnt;
    bit   got_done;
    e.exc = exc_model(st, f, a);
    if (e.exc == 2'b00 && ack_on == 0) e.exc = 2'b10;
    e.rdata = (e.exc == 2'b00 && !st) ? ld_model(f, a[1:0], rword) : model_rdata;
    model_rdata = e.rdata;
    exp_reqs = (e.exc == 2'b01 || e.exc == 2'b11) ? 0 : (e.exc == 2'b10) ? TMO : ack_on;
    exp_lat  = exp_reqs + 1;

    @(negedge clk);
    ls_valid = 1'b1; opcode = st ? OP_ST : OP_LD; fn3 = f; addr = a; wdata = wd;
    mem_rdata = rword;
    sb_q.push_back(e);
    #1 check({nm, "_stall_t0"}, 32'(stall), 32'd1);

    cyc = 0; req_cnt = 0; got_done = 0;
    while (!got_done && cyc < 50) begin
      @(negedge clk);
      cyc++;
      if (mem_req) begin
        req_cnt++;
        if (req_cnt == 1) begin
          check({nm, "_maddr"}, mem_addr, {a[31:2], 2'b00});
          check({nm, "_mwe"}, 32'(mem_we), 32'(st));
          check({nm, "_wstrb"}, 32'(mem_wstrb), st ? 32'(strb_model(f, a[1:0])) : 32'd0);
          if (st) check({nm, "_mwdata"}, mem_wdata, wd_model(f, wd));
        end
        mem_ack = (req_cnt == ack_on);
      end else begin
        mem_ack = 1'b0;
      end
      if (done) begin
        got_done = 1;
        ls_valid = 1'b0;
        if (sb_q.size() == 0) begin
          check({nm, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
          e = sb_q.pop_front();
          check({nm, "_rdata"}, rdata, e.rdata);
          check({nm, "_exc"}, 32'(exc_code), 32'(e.exc));
        end
        check({nm, "_stall_done"}, 32'(stall), 32'd0);
        check({nm, "_latency"}, 32'(cyc), 32'(exp_lat));
        check({nm, "_reqs"}, 32'(req_cnt), 32'(exp_reqs));
      end else begin
        check({nm, "_stall_busy"}, 32'(stall), 32'd1);
      end
    end
    if (!got_done) check({nm, "_no_done"}, 32'd0, 32'd1);
    ls_valid = 1'b0;
    mem_ack  = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; ls_valid = 1'b0; mem_ack = 1'b0; opcode = 7'h0; fn3 = 3'h0;
    addr = 32'h0; wdata = 32'h0; mem_rdata = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_exc", 32'(exc_code), 32'd0);
    check("rst_req", 32'(mem_req), 32'd0);
    check("rst_maddr", mem_addr, 32'h0);
    check("rst_wstrb", 32'(mem_wstrb), 32'd0);
    rst = 1'b0;

    // Non-memory opcode is ignored.
    @(negedge clk);
    ls_valid = 1'b1; opcode = 7'b0110011; fn3 = 3'b010; addr = 32'h100;
    #1 check("ign_stall", 32'(stall), 32'd0);
    @(negedge clk);
    check("ign_req", 32'(mem_req), 32'd0);
    check("ign_done", 32'(done), 32'd0);
    ls_valid = 1'b0;

    run_op("lw",   1'b0, 3'b010, 32'h0000_0100, 32'h0, 32'hDEADBEEF, 3);
    run_op("lb",   1'b0, 3'b000, 32'h0000_0203, 32'h0, 32'h80112233, 1);
    run_op("lbu",  1'b0, 3'b100, 32'h0000_0203, 32'h0, 32'h80112233, 2);
    run_op("lh",   1'b0, 3'b001, 32'h0000_0202, 32'h0, 32'h80112233, 1);
    run_op("lhu",  1'b0, 3'b101, 32'h0000_0200, 32'h0, 32'h1234F00D, 1);
    run_op("sb",   1'b1, 3'b000, 32'h0000_0301, 32'h0000_00A5, 32'h0, 1);
    run_op("sh",   1'b1, 3'b001, 32'h0000_0302, 32'h1234_ABCD, 32'h0, 2);
    run_op("sw",   1'b1, 3'b010, 32'h0000_0304, 32'hCAFE_0123, 32'h0, 1);
    run_op("mis",  1'b0, 3'b010, 32'h0000_0102, 32'h0, 32'h5555_5555, 1);
    run_op("ill",  1'b1, 3'b100, 32'h0000_0100, 32'h0, 32'h0, 1);
    run_op("both", 1'b0, 3'b011, 32'h0000_0101, 32'h0, 32'h0, 1);
    run_op("tmo",  1'b0, 3'b010, 32'h0000_0108, 32'h0, 32'h0, 0);

    // Late ack arriving in IDLE must have no effect.
    @(negedge clk); mem_ack = 1'b1;
    @(negedge clk); mem_ack = 1'b0;
    check("late_ack_req", 32'(mem_req), 32'd0);
    check("late_ack_done", 32'(done), 32'd0);
    check("late_ack_rdata", rdata, model_rdata);
    @(negedge clk);
    check("late_ack_done2", 32'(done), 32'd0);

    // Reset during the 2nd REQ cycle abandons the transaction.
    @(negedge clk);
    ls_valid = 1'b1; opcode = OP_LD; fn3 = 3'b010; addr = 32'h400; mem_rdata = 32'h0;
    n = 0;
    while (n < 2 && vectors < 100000) begin
      @(negedge clk);
      if (mem_req) n++;
      else begin check("rst_mid_no_req", 32'(mem_req), 32'd1); n = 2; end
    end
    rst = 1'b1; ls_valid = 1'b0;
    @(negedge clk);
    check("rst_mid_req", 32'(mem_req), 32'd0);
    check("rst_mid_stall", 32'(stall), 32'd0);
    check("rst_mid_done", 32'(done), 32'd0);
    rst = 1'b0;
    model_rdata = 32'h0;
    @(negedge clk);
    check("rst_mid_done2", 32'(done), 32'd0);
    check("rst_mid_rdata", rdata, 32'h0);
    run_op("lw2", 1'b0, 3'b010, 32'h0000_0410, 32'h0, 32'h0BAD_F00D, 2);

    check("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
